// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard detection and operand-forwarding control for the
// in-order RV32I pipeline. A shadow copy of destination-register metadata is
// kept for each stage from EX (stage 0) to WB (stage FWD_DEPTH-1). From it the
// unit derives forward selects for EX and for the decode branch comparator,
// load-use / branch-use stalls, the fetch flush on redirect, and the memory
// wait freeze.
//
// Control handshake: the unit has no valid/ready channel. Every control output
// is combinational from the current shadow state and the decode inputs, and
// the shadow state advances on each rising clk edge unless mem_busy freezes it.
module hazard_fwd_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_DEPTH      = 3,
  parameter int LOAD_READY     = 2,
  localparam int SELW          = $clog2(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      id_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_en,
  input  logic                      id_is_load,
  input  logic                      redirect,
  input  logic                      mem_busy,
  output logic                      stall_fe,
  output logic                      bubble_ex,
  output logic                      flush_fe,
  output logic                      freeze,
  output logic [SELW-1:0]           fwd_a_sel,
  output logic [SELW-1:0]           fwd_b_sel,
  output logic [SELW-1:0]           br_a_sel,
  output logic [SELW-1:0]           br_b_sel,
  output logic [31:0]               stall_cycles
);

  localparam int RW = REG_ADDR_WIDTH;
  // Stage indices are at most 6, so k and k+1 both fit in 3 bits.
  localparam int KW = 3;

  // Shadow pipeline, one entry per tracked stage.
  logic [FWD_DEPTH-1:0] vld_q, vld_d;
  logic [FWD_DEPTH-1:0] reg_en_q, reg_en_d;
  logic [FWD_DEPTH-1:0] ld_q, ld_d;
  logic [RW-1:0]        rd_q [FWD_DEPTH];
  logic [RW-1:0]        rd_d [FWD_DEPTH];

  // Source operands of the instruction currently in EX.
  logic [RW-1:0] ex_rs1_q, ex_rs1_d;
  logic [RW-1:0] ex_rs2_q, ex_rs2_d;
  logic          ex_use1_q, ex_use1_d;
  logic          ex_use2_q, ex_use2_d;

  logic [31:0]   stall_cnt_q, stall_cnt_d;

  // Source slots: 0/1 = EX rs1/rs2, 2/3 = decode rs1/rs2.
  logic [RW-1:0] src   [4];
  logic [3:0]    use_v;
  logic [3:0]    hit;
  logic [KW-1:0] hit_k [4];
  logic [3:0]    hit_ld;
  logic [3:0]    rdy_here;
  logic [3:0]    rdy_next;
  logic          hazard;

  assign src[0]   = ex_rs1_q;
  assign src[1]   = ex_rs2_q;
  assign src[2]   = id_rs1;
  assign src[3]   = id_rs2;
  assign use_v[0] = ex_use1_q;
  assign use_v[1] = ex_use2_q;
  assign use_v[2] = id_use_rs1;
  assign use_v[3] = id_use_rs2;

  // A producer at stage k can supply its result: loads only from LOAD_READY on.
  function automatic logic ready_at(input logic is_ld, input int k);
    return is_ld ? (k >= LOAD_READY) : (k >= 1);
  endfunction

  // Youngest matching producer per source; scan oldest->youngest so the
  // youngest hit is the last one written. EX sources never look at stage 0,
  // which is the consumer itself.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      hit[s]    = 1'b0;
      hit_k[s]  = '0;
      hit_ld[s] = 1'b0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if ((s >= 2 || k >= 1) && vld_q[k] && reg_en_q[k] &&
            (rd_q[k] != '0) && (rd_q[k] == src[s]) && use_v[s]) begin
          hit[s]    = 1'b1;
          hit_k[s]  = KW'(k);
          hit_ld[s] = ld_q[k];
        end
      end
      rdy_here[s] = ready_at(hit_ld[s], int'(hit_k[s]));
      rdy_next[s] = ready_at(hit_ld[s], int'(hit_k[s]) + 1);
    end
  end

  // Hazard, pipeline control and forward selects.
  always_comb begin
    hazard = 1'b0;
    for (int s = 2; s < 4; s++) begin
      if (hit[s] && (id_is_branch ? !rdy_here[s] : !rdy_next[s]))
        hazard = 1'b1;
    end
    hazard = hazard && id_valid;

    freeze    = mem_busy;
    stall_fe  = mem_busy || hazard;
    bubble_ex = !mem_busy && hazard;
    flush_fe  = !mem_busy && !hazard && redirect;

    fwd_a_sel = hit[0] ? SELW'(hit_k[0]) : '0;
    fwd_b_sel = hit[1] ? SELW'(hit_k[1]) : '0;
    br_a_sel  = (hit[2] && rdy_here[2]) ? SELW'(hit_k[2]) : '0;
    br_b_sel  = (hit[3] && rdy_here[3]) ? SELW'(hit_k[3]) : '0;

    stall_cycles = stall_cnt_q;
  end

  // Next shadow state: shift one stage, insert decode or a bubble, hold on freeze.
  always_comb begin
    vld_d       = vld_q;
    reg_en_d    = reg_en_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_use1_d   = ex_use1_q;
    ex_use2_d   = ex_use2_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_busy) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        vld_d[k]    = vld_q[k-1];
        reg_en_d[k] = reg_en_q[k-1];
        ld_d[k]     = ld_q[k-1];
        rd_d[k]     = rd_q[k-1];
      end
      if (id_valid && !hazard) begin
        vld_d[0]    = 1'b1;
        reg_en_d[0] = id_reg_en;
        ld_d[0]     = id_is_load;
        rd_d[0]     = id_rd;
        ex_rs1_d    = id_rs1;
        ex_rs2_d    = id_rs2;
        ex_use1_d   = id_use_rs1;
        ex_use2_d   = id_use_rs2;
      end else begin
        vld_d[0]    = 1'b0;
        reg_en_d[0] = 1'b0;
        ld_d[0]     = 1'b0;
        rd_d[0]     = '0;
        ex_rs1_d    = '0;
        ex_rs2_d    = '0;
        ex_use1_d   = 1'b0;
        ex_use2_d   = 1'b0;
      end
      if (hazard && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      reg_en_q    <= '0;
      ld_q        <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) rd_q[k] <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      reg_en_q    <= reg_en_d;
      ld_q        <= ld_d;
      for (int k = 0; k < FWD_DEPTH; k++) rd_q[k] <= rd_d[k];
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_use1_q   <= ex_use1_d;
      ex_use2_q   <= ex_use2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a default instance (FWD_DEPTH=3,
// LOAD_READY=2) and a deeper one (FWD_DEPTH=5, LOAD_READY=3) share stimulus.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_is_branch, id_reg_en, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       redirect, mem_busy;

  logic        stall_fe, bubble_ex, flush_fe, freeze;
  logic [1:0]  fwd_a_sel, fwd_b_sel, br_a_sel, br_b_sel;
  logic [31:0] stall_cycles;

  logic        stall_fe2, bubble_ex2, flush_fe2, freeze2;
  logic [2:0]  fwd_a_sel2, fwd_b_sel2, br_a_sel2, br_b_sel2;
  logic [31:0] stall_cycles2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
    .id_rd(id_rd), .id_reg_en(id_reg_en), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy), .stall_fe(stall_fe),
    .bubble_ex(bubble_ex), .flush_fe(flush_fe), .freeze(freeze),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .br_a_sel(br_a_sel),
    .br_b_sel(br_b_sel), .stall_cycles(stall_cycles)
  );

  hazard_fwd_unit #(.FWD_DEPTH(5), .LOAD_READY(3)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
    .id_rd(id_rd), .id_reg_en(id_reg_en), .id_is_load(id_is_load),
    .redirect(redirect), .mem_busy(mem_busy), .stall_fe(stall_fe2),
    .bubble_ex(bubble_ex2), .flush_fe(flush_fe2), .freeze(freeze2),
    .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .br_a_sel(br_a_sel2),
    .br_b_sel(br_b_sel2), .stall_cycles(stall_cycles2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one decode-stage instruction (or idle when v=0).
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic br,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic redir);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_is_branch = br; id_rd = rd; id_reg_en = we; id_is_load = ld; redirect = redir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; return 1 ns after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    rst = 1'b1; mem_busy = 1'b1; idle();
    tick();
    chk("rst_freeze_follows_busy", {31'd0, freeze}, 32'd1);
    mem_busy = 1'b0;
    tick();
    chk("rst_stall_fe", {31'd0, stall_fe}, 32'd0);
    chk("rst_bubble", {31'd0, bubble_ex}, 32'd0);
    chk("rst_flush", {31'd0, flush_fe}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("rst_br_a", {30'd0, br_a_sel}, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    rst = 1'b0;
    tick();

    // 1. ALU producer immediately followed by a consumer.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alu_no_stall", {31'd0, stall_fe}, 32'd0);
    chk("alu_no_bubble", {31'd0, bubble_ex}, 32'd0);
    tick();
    idle();
    #1;
    chk("alu_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    chk("alu_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
    chk("alu_cnt", stall_cycles, 32'd0);
    drain();

    // 2. Load-use: one stall, then forward from stage 2.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'd0, stall_fe}, 32'd1);
    chk("lu_bubble", {31'd0, bubble_ex}, 32'd1);
    tick();
    chk("lu_released", {31'd0, stall_fe}, 32'd0);
    chk("lu_cnt", stall_cycles, 32'd1);
    tick();
    idle();
    #1;
    chk("lu_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("lu_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    drain();

    // 3. Branch right after an ALU producer of its operand.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("br_stall", {31'd0, stall_fe}, 32'd1);
    chk("br_flush_blocked", {31'd0, flush_fe}, 32'd0);
    chk("br_sel_not_ready", {30'd0, br_a_sel}, 32'd0);
    tick();
    chk("br_sel_a", {30'd0, br_a_sel}, 32'd1);
    chk("br_sel_b_x0", {30'd0, br_b_sel}, 32'd0);
    chk("br_flush", {31'd0, flush_fe}, 32'd1);
    chk("br_no_stall", {31'd0, stall_fe}, 32'd0);
    chk("br_cnt", stall_cycles, 32'd2);
    drain();

    // 4. Youngest of two writers to x8 wins; x0 is never forwarded.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("young_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    drain();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("x0_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("x0_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // 5. Freeze for 3 cycles during a load-use stall.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_stall", {31'd0, stall_fe}, 32'd1);
      chk("frz_bubble", {31'd0, bubble_ex}, 32'd0);
      chk("frz_flag", {31'd0, freeze}, 32'd1);
      chk("frz_cnt_hold", stall_cycles, 32'd2);
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_rel_stall", {31'd0, stall_fe}, 32'd1);
    chk("frz_rel_bubble", {31'd0, bubble_ex}, 32'd1);
    tick();
    chk("frz_done", {31'd0, stall_fe}, 32'd0);
    chk("frz_cnt", stall_cycles, 32'd3);
    tick();
    idle();
    #1;
    chk("frz_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("frz_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    drain();

    // 6. Reset during a branch-use stall.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rstbr_stall", {31'd0, stall_fe}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstbr_stall_gone", {31'd0, stall_fe}, 32'd0);
    chk("rstbr_br_a", {30'd0, br_a_sel}, 32'd0);
    chk("rstbr_br_b", {30'd0, br_b_sel}, 32'd0);
    chk("rstbr_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("rstbr_cnt", stall_cycles, 32'd0);
    drain();

    // Deep instance: load-use costs two stalls, then forward from stage 3.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("deep_stall1", {31'd0, stall_fe2}, 32'd1);
    tick();
    chk("deep_stall2", {31'd0, stall_fe2}, 32'd1);
    tick();
    chk("deep_released", {31'd0, stall_fe2}, 32'd0);
    chk("deep_cnt", stall_cycles2, 32'd2);
    tick();
    idle();
    #1;
    chk("deep_fwd_a", {29'd0, fwd_a_sel2}, 32'd3);
    chk("deep_fwd_b", {29'd0, fwd_b_sel2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
